int_unit_arbiter: RTL and testbench

Round-robin controller that shares one 32-bit integer compute unit (one `int` operand in, one `int` result out, start/done handshake) between `N_REQ` requesters. It accepts one request at a time, loads the operand into the unit, waits for completion and returns the result to the originating requester. It sits between requester ports and a single instance of the shared unit inside the enclosing entity. There is exactly one operation in flight.

---
 rtl/int_unit_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_int_unit_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit compute unit between N_REQ requesters.
// Optional WAIT watchdog enabled by defining INT_ARB_TIMEOUT_EN.
module int_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_b,
  output logic                 rsp_err,
  output logic                 unit_start,
  output logic [31:0]          unit_a,
  input  logic [31:0]          unit_b,
  input  logic                 unit_done,
  output logic                 busy,
  output logic [IDW-1:0]       cur_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic [31:0]        op_q, op_d;
  logic [31:0]        rsp_b_q, rsp_b_d;
  logic               start_q, start_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic               win_found_s;
  logic [IDW-1:0]     win_id_s;
  logic [IDW-1:0]     idx_s;
  logic               accept_s;
`ifdef INT_ARB_TIMEOUT_EN
  logic               err_q, err_d;
  logic [7:0]         wd_q, wd_d;
`endif

  // Round-robin search: first asserted request starting after the last served owner.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    idx_s       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = IDW'((int'(last_q) + k + 32'sd1) % N_REQ);
      if (!win_found_s && req_valid[idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant is combinational but forced low while reset is applied.
  always_comb begin
    req_ready = '0;
    accept_s  = 1'b0;
    if (!rst && (state_q == ST_IDLE) && win_found_s) begin
      req_ready[win_id_s] = 1'b1;
      accept_s            = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state and datapath updates for the single in-flight operation.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_id_d = cur_id_q;
    op_d     = op_q;
    rsp_b_d  = rsp_b_q;
`ifdef INT_ARB_TIMEOUT_EN
    err_d    = err_q;
    wd_d     = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d     = req_a[{win_id_s, 5'd0} +: 32];
          cur_id_d = win_id_s;
`ifdef INT_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
`ifdef INT_ARB_TIMEOUT_EN
        wd_d    = 8'd0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (unit_done) begin
          rsp_b_d = unit_b;
`ifdef INT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
`ifdef INT_ARB_TIMEOUT_EN
        end else if (wd_q == 8'd254) begin
          // 255th cycle in WAIT without completion: abort with an error result.
          rsp_b_d = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d    = wd_q + 8'd1;
          state_d = ST_WAIT;
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready[cur_id_q]) begin
          last_d  = cur_id_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flags are derived from the next state so they are plain flops.
  always_comb begin
    start_d     = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = '0;
    if (state_d == ST_RESP) begin
      rsp_valid_d[cur_id_d] = 1'b1;
    end else begin
      rsp_valid_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(N_REQ - 1);
      cur_id_q    <= '0;
      op_q        <= 32'h0;
      rsp_b_q     <= 32'h0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cur_id_q    <= cur_id_d;
      op_q        <= op_d;
      rsp_b_q     <= rsp_b_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef INT_ARB_TIMEOUT_EN
  // Watchdog counter and abort flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      wd_q  <= 8'd0;
    end else begin
      err_q <= err_d;
      wd_q  <= wd_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign unit_start = start_q;
  assign unit_a     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_b      = rsp_b_q;
  assign busy       = busy_q;
  assign cur_id     = cur_id_q;

endmodule

// File: tb/tb_int_unit_arbiter.sv
// Directed bench for int_unit_arbiter: scoreboard queues of expected grants and
// responses, popped by a monitor on the falling edge.
module tb_int_unit_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_b;
  logic         rsp_err;
  logic         unit_start;
  logic [31:0]  unit_a;
  logic [31:0]  unit_b;
  logic         unit_done;
  logic         busy;
  logic [1:0]   cur_id;

  typedef struct {
    int          id;
    logic [31:0] b;
    logic        err;
  } rsp_t;

  int   exp_grant[$];
  rsp_t exp_rsp[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic unit_en, stray, start_seen;
  logic [31:0] stray_b;

  always #5 clk = ~clk;

  int_unit_arbiter #(.N_REQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_b(rsp_b), .rsp_err(rsp_err), .unit_start(unit_start),
    .unit_a(unit_a), .unit_b(unit_b), .unit_done(unit_done),
    .busy(busy), .cur_id(cur_id)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; the unit model answers a+2 one cycle after seeing start.
  task automatic tick();
    @(posedge clk);
    #1;
    if (start_seen && unit_en) begin
      unit_done = 1'b1;
      unit_b    = unit_a + 32'd2;
    end else begin
      unit_done = stray;
      if (stray) unit_b = stray_b;
    end
    stray      = 1'b0;
    start_seen = unit_start;
    cyc++;
  endtask

  task automatic push_rsp(input int id, input logic [31:0] b, input logic err);
    rsp_t e;
    e.id = id; e.b = b; e.err = err;
    exp_rsp.push_back(e);
  endtask

  task automatic wait_rsp(input string name, input int budget);
    int n = 0;
    while (rsp_valid == 4'b0000 && n < budget) begin
      tick();
      n++;
    end
    if (rsp_valid == 4'b0000) begin
      checks++; failures++;
      $display("FAIL %s: no rsp_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic monitor();
    int   g;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|(req_valid & req_ready)) begin
          if (exp_grant.size() == 0) begin
            checks++; failures++;
            $display("FAIL grant_unexpected: got %b expected none", req_ready);
          end else begin
            g = exp_grant.pop_front();
            chk("grant", req_ready, 4'b0001 << g);
          end
        end
        if (|(rsp_valid & rsp_ready)) begin
          if (exp_rsp.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: got %b expected none", rsp_valid);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_id", rsp_valid, 4'b0001 << e.id);
            chk("rsp_b", rsp_b, e.b);
            chk("rsp_err", rsp_err, e.err);
          end
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t0, n;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = {32'd13, 32'd12, 32'd11, 32'd10};
    rsp_ready  = 4'b1111;
    unit_b     = 32'd0;
    unit_done  = 1'b0;
    unit_en    = 1'b1;
    stray      = 1'b0;
    stray_b    = 32'd0;
    start_seen = 1'b0;
    fork
      monitor();
    join_none

    #12;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_unit_start", unit_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_b", rsp_b, 32'd0);
    chk("rst_unit_a", unit_a, 32'd0);
    chk("rst_cur_id", cur_id, 2'd0);
    tick();
    rst = 1'b0;
    #1;

    // Round robin with everybody requesting.
    chk("rr_first_ready", req_ready, 4'b0001);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    push_rsp(0, 32'd12, 1'b0); push_rsp(1, 32'd13, 1'b0); push_rsp(2, 32'd14, 1'b0);
    push_rsp(3, 32'd15, 1'b0); push_rsp(0, 32'd12, 1'b0);
    acc = 0; t0 = 0; n = 0;
    while (acc < 5 && n < 60) begin
      if (|(req_valid & req_ready)) begin
        acc++;
        if (acc == 2) chk("rr_interval", cyc - t0, 4);
        t0 = cyc;
      end
      tick();
      n++;
    end
    req_valid = 4'b0000;
    chk("rr_grant_count", acc, 5);
    wait_idle("rr_idle", 40);

    // Single request with cycle-exact timing.
    req_a[95:64] = 32'd40;
    req_valid = 4'b0100;
    exp_grant.push_back(2);
    push_rsp(2, 32'd42, 1'b0);
    #1;
    chk("single_c0_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk("single_c1_start", unit_start, 1'b1);
    chk("single_c1_unit_a", unit_a, 32'd40);
    chk("single_c1_busy", busy, 1'b1);
    chk("single_c1_cur_id", cur_id, 2'd2);
    tick();
    chk("single_c2_start", unit_start, 1'b0);
    chk("single_c2_rsp_valid", rsp_valid, 4'b0000);
    tick();
    chk("single_c3_rsp_valid", rsp_valid, 4'b0100);
    chk("single_c3_rsp_b", rsp_b, 32'd42);
    tick();
    chk("single_c4_busy", busy, 1'b0);

    // Response backpressure on requester 1 plus a stray done while in RESP.
    req_a[63:32] = 32'd7;
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    exp_grant.push_back(1);
    push_rsp(1, 32'd9, 1'b0);
    #1;
    tick();
    req_valid = 4'b1101;
    wait_rsp("bp_rsp", 10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 4'b0010);
      chk("bp_rsp_b", rsp_b, 32'd9);
      chk("bp_req_ready", req_ready, 4'b0000);
      if (i == 1) begin
        stray   = 1'b1;
        stray_b = 32'd99;
      end
      tick();
    end
    chk("bp_still_valid", rsp_valid, 4'b0010);
    rsp_ready = 4'b1111;
    req_valid = 4'b0000;
    tick();
    chk("bp_idle", busy, 1'b0);

    // Stray done while idle.
    stray   = 1'b1;
    stray_b = 32'd77;
    tick();
    chk("stray_busy", busy, 1'b0);
    tick();
    chk("stray_busy2", busy, 1'b0);
    chk("stray_rsp_b", rsp_b, 32'd9);
    chk("stray_rsp_valid", rsp_valid, 4'b0000);
    chk("stray_start", unit_start, 1'b0);

    // Reset while WAIT is blocked on a silent unit.
    unit_en   = 1'b0;
    req_valid = 4'b1111;
    exp_grant.push_back(2);
    #1;
    chk("rstw_grant", req_ready, 4'b0100);
    tick();
    tick();
    tick();
    chk("rstw_busy", busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("rstw_start", unit_start, 1'b0);
    chk("rstw_busy0", busy, 1'b0);
    chk("rstw_rsp_valid", rsp_valid, 4'b0000);
    chk("rstw_req_ready", req_ready, 4'b0000);
    chk("rstw_unit_a", unit_a, 32'd0);
    chk("rstw_cur_id", cur_id, 2'd0);
    tick();
    rst = 1'b0;
    unit_en = 1'b1;
    exp_grant.push_back(0);
    push_rsp(0, 32'd12, 1'b0);
    #1;
    chk("rstw_first_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    wait_rsp("rstw_rsp", 10);
    wait_idle("rstw_idle", 10);

`ifdef INT_ARB_TIMEOUT_EN
    // Silent unit: watchdog aborts after 255 cycles in WAIT.
    unit_en   = 1'b0;
    req_valid = 4'b0001;
    exp_grant.push_back(0);
    push_rsp(0, 32'd0, 1'b1);
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    n = 0;
    while (rsp_valid == 4'b0000 && n < 300) begin
      tick();
      n++;
    end
    chk("to_latency", n, 255);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rsp_b", rsp_b, 32'd0);
    wait_idle("to_idle", 10);
    unit_en   = 1'b1;
    req_valid = 4'b0001;
    exp_grant.push_back(0);
    push_rsp(0, 32'd12, 1'b0);
    #1;
    tick();
    req_valid = 4'b0000;
    chk("to_err_cleared", rsp_err, 1'b0);
    wait_rsp("to_rsp2", 10);
    wait_idle("to_idle2", 10);
`endif

    tick();
    tick();
    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
